// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_sync_gen
// Purpose : VGA raster timing generator (pixel enable, counters, syncs, blanking)
// Revision: 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int CLK_DIV     = 2,
    parameter int SYNC_ACTIVE = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        pix_tick,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_end,
    output logic        frame_tick
);

    localparam logic [10:0] c_H_TOTAL  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [10:0] c_V_TOTAL  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [10:0] c_H_LAST   = c_H_TOTAL - 11'd1;
    localparam logic [10:0] c_V_LAST   = c_V_TOTAL - 11'd1;
    localparam logic [10:0] c_H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] c_V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] c_HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        c_SYNC_ON  = 1'(SYNC_ACTIVE);

    logic        w_pix_tick;
    logic [10:0] r_h;
    logic [10:0] r_v;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_hs_win;
    logic        w_vs_win;

    generate
        if (CLK_DIV > 1) begin : g_div
            localparam int          c_DIV_W = $clog2(CLK_DIV);
            localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

            logic [c_DIV_W-1:0] r_div_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_div_cnt <= '0;
                end else if (r_div_cnt == c_DIV_LAST) begin
                    r_div_cnt <= '0;
                end else begin
                    r_div_cnt <= r_div_cnt + 1'b1;
                end
            end

            assign w_pix_tick = (r_div_cnt == c_DIV_LAST);
        end else begin : g_nodiv
            assign w_pix_tick = 1'b1;
        end
    endgenerate

    assign w_h_last = (r_h == c_H_LAST);
    assign w_v_last = (r_v == c_V_LAST);

    // Reset wins over the pixel enable, so a mid-frame reset never finishes the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h <= 11'd0;
            r_v <= 11'd0;
        end else if (w_pix_tick) begin
            if (w_h_last) begin
                r_h <= 11'd0;
                r_v <= w_v_last ? 11'd0 : r_v + 11'd1;
            end else begin
                r_h <= r_h + 11'd1;
            end
        end
    end

    assign w_hs_win = (r_h >= c_HS_START) && (r_h < c_HS_END);
    assign w_vs_win = (r_v >= c_VS_START) && (r_v < c_VS_END);

    assign pix_tick   = w_pix_tick;
    assign pix_x      = r_h;
    assign pix_y      = r_v;
    assign hsync      = w_hs_win ? c_SYNC_ON : ~c_SYNC_ON;
    assign vsync      = w_vs_win ? c_SYNC_ON : ~c_SYNC_ON;
    assign video_on   = (r_h < c_H_VIS) && (r_v < c_V_VIS);
    assign line_end   = w_pix_tick && w_h_last;
    assign frame_tick = w_pix_tick && w_h_last && w_v_last;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_sync_gen
// Purpose : Self-checking bench for vga_sync_gen (default, small and fast rasters)
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    typedef struct packed {
        logic        tick;
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        vo;
        logic        le;
        logic        ft;
    } obs_t;

    typedef struct {
        int          k;
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vo;
        logic        le;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        d_tick, d_hs, d_vs, d_vo, d_le, d_ft;
    logic [10:0] d_x, d_y;
    logic        s_tick, s_hs, s_vs, s_vo, s_le, s_ft;
    logic [10:0] s_x, s_y;
    logic        f_tick, f_hs, f_vs, f_vo, f_le, f_ft;
    logic [10:0] f_x, f_y;

    vga_sync_gen u_def (
        .clk(clk), .reset(reset), .pix_tick(d_tick), .pix_x(d_x), .pix_y(d_y),
        .hsync(d_hs), .vsync(d_vs), .video_on(d_vo), .line_end(d_le), .frame_tick(d_ft)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(3), .SYNC_ACTIVE(0)
    ) u_sml (
        .clk(clk), .reset(reset), .pix_tick(s_tick), .pix_x(s_x), .pix_y(s_y),
        .hsync(s_hs), .vsync(s_vs), .video_on(s_vo), .line_end(s_le), .frame_tick(s_ft)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1), .SYNC_ACTIVE(1)
    ) u_fast (
        .clk(clk), .reset(reset), .pix_tick(f_tick), .pix_x(f_x), .pix_y(f_y),
        .hsync(f_hs), .vsync(f_vs), .video_on(f_vo), .line_end(f_le), .frame_tick(f_ft)
    );

    obs_t o_def, o_sml, o_fast;
    assign o_def  = {d_tick, d_x, d_y, d_hs, d_vs, d_vo, d_le, d_ft};
    assign o_sml  = {s_tick, s_x, s_y, s_hs, s_vs, s_vo, s_le, s_ft};
    assign o_fast = {f_tick, f_x, f_y, f_hs, f_vs, f_vo, f_le, f_ft};

    int   n_checks = 0;
    int   n_errors = 0;
    int   k = 0;
    obs_t q_def[$];
    obs_t q_sml[$];
    obs_t q_fast[$];

    // Expected raster state k clocks after the last reset edge.
    function automatic obs_t model(input int kk, input int ha, input int hf, input int hs,
                                   input int hb, input int va, input int vf, input int vs,
                                   input int vb, input int d, input int sa);
        obs_t o;
        int ht, vt, p, h, v;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        p  = kk / d;
        h  = p % ht;
        v  = (p / ht) % vt;
        o.tick = ((kk % d) == d - 1);
        o.x    = 11'(h);
        o.y    = 11'(v);
        o.hs   = (h >= ha + hf && h < ha + hf + hs) ? 1'(sa) : ~1'(sa);
        o.vs   = (v >= va + vf && v < va + vf + vs) ? 1'(sa) : ~1'(sa);
        o.vo   = (h < ha) && (v < va);
        o.le   = o.tick && (h == ht - 1);
        o.ft   = o.le && (v == vt - 1);
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s k=%0d: got tick=%b x=%0d y=%0d hs=%b vs=%b vo=%b le=%b ft=%b, expected tick=%b x=%0d y=%0d hs=%b vs=%b vo=%b le=%b ft=%b",
                     name, k, act.tick, act.x, act.y, act.hs, act.vs, act.vo, act.le, act.ft,
                     exp.tick, exp.x, exp.y, exp.hs, exp.vs, exp.vo, exp.le, exp.ft);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r);
        int kn;
        reset = r;
        kn = r ? 0 : k + 1;
        q_def.push_back(model(kn, 640, 16, 96, 48, 480, 10, 2, 33, 2, 0));
        q_sml.push_back(model(kn, 8, 2, 3, 2, 6, 1, 2, 1, 3, 0));
        q_fast.push_back(model(kn, 8, 2, 3, 2, 6, 1, 2, 1, 1, 1));
        @(posedge clk);
        @(negedge clk);
        k = kn;
        check_obs("sb_def", o_def, q_def.pop_front());
        check_obs("sb_sml", o_sml, q_sml.pop_front());
        check_obs("sb_fast", o_fast, q_fast.pop_front());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        obs_t rst_lo;
        obs_t rst_fast;
        int   n, k1, k2, run, lines, adv_s, adv_d;

        vecs[0]  = '{1,    11'd0,   11'd0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{2,    11'd1,   11'd0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{3,    11'd1,   11'd0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1278, 11'd639, 11'd0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1279, 11'd639, 11'd0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1280, 11'd640, 11'd0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1311, 11'd655, 11'd0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1312, 11'd656, 11'd0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1503, 11'd751, 11'd0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1504, 11'd752, 11'd0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1598, 11'd799, 11'd0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1599, 11'd799, 11'd0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1600, 11'd0,   11'd1, 1'b1, 1'b1, 1'b0};

        rst_lo   = '{1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        rst_fast = '{1'b1, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        @(negedge clk);
        step(1'b1);
        step(1'b1);
        check_obs("reset_def", o_def, rst_lo);
        check_obs("reset_sml", o_sml, rst_lo);
        check_obs("reset_fast", o_fast, rst_fast);

        for (int i = 0; i < 13; i++) begin
            n = 0;
            while (k < vecs[i].k && n < 2000) begin
                step(1'b0);
                n++;
            end
            n_checks++;
            if ({o_def.x, o_def.y, o_def.hs, o_def.vo, o_def.le} !==
                {vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vo, vecs[i].le}) begin
                n_errors++;
                $display("FAIL vec%0d k=%0d: got x=%0d y=%0d hs=%b vo=%b le=%b, expected x=%0d y=%0d hs=%b vo=%b le=%b",
                         i, k, o_def.x, o_def.y, o_def.hs, o_def.vo, o_def.le,
                         vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vo, vecs[i].le);
            end
        end

        // Default hsync window: edges and width in system clocks.
        n = 0;
        while (o_def.hs !== 1'b0 && n < 2000) begin step(1'b0); n++; end
        check_int("hsync_fall_x", int'(o_def.x), 656);
        run = 0;
        while (o_def.hs === 1'b0 && run < 2000) begin step(1'b0); run++; end
        check_int("hsync_low_clks", run, 192);
        check_int("hsync_rise_x", int'(o_def.x), 752);

        n = 0;
        while (o_def.le !== 1'b1 && n < 2000) begin step(1'b0); n++; end
        k1 = k;
        step(1'b0);
        n = 0;
        while (o_def.le !== 1'b1 && n < 2000) begin step(1'b0); n++; end
        k2 = k;
        check_int("line_end_period", k2 - k1, 1600);

        // Small raster: frame wrap, pulse width, line count, frame period.
        n = 0;
        while (o_sml.ft !== 1'b1 && n < 1000) begin step(1'b0); n++; end
        check_int("sml_ft_at_last", int'({o_sml.x, o_sml.y}), int'({11'd14, 11'd9}));
        k1 = k;
        step(1'b0);
        check_int("sml_ft_width", int'(o_sml.ft), 0);
        check_int("sml_wrap_xy", int'({o_sml.x, o_sml.y}), 0);
        lines = 0;
        n = 0;
        do begin
            step(1'b0);
            n++;
            if (o_sml.le === 1'b1) lines++;
        end while (o_sml.ft !== 1'b1 && n < 1000);
        check_int("sml_frame_clks", k - k1, 450);
        check_int("sml_lines_per_frame", lines, 10);

        // Fast raster (no divider, active-high syncs).
        n = 0;
        while (o_fast.ft !== 1'b1 && n < 1000) begin step(1'b0); n++; end
        k1 = k;
        step(1'b0);
        n = 0;
        while (o_fast.ft !== 1'b1 && n < 1000) begin step(1'b0); n++; end
        check_int("fast_frame_clks", k - k1, 150);
        n = 0;
        while (o_fast.hs !== 1'b1 && n < 1000) begin step(1'b0); n++; end
        check_int("fast_hs_rise_x", int'(o_fast.x), 10);
        run = 0;
        while (o_fast.hs === 1'b1 && run < 1000) begin step(1'b0); run++; end
        check_int("fast_hs_high_clks", run, 3);

        // Mid-frame reset.
        n = 0;
        while (!(o_sml.x == 11'd5 && o_sml.y == 11'd4) && n < 1000) begin step(1'b0); n++; end
        check_int("sml_reach_5_4", int'({o_sml.x, o_sml.y}), int'({11'd5, 11'd4}));
        step(1'b1);
        check_obs("midreset_sml", o_sml, rst_lo);
        check_obs("midreset_def", o_def, rst_lo);
        check_obs("midreset_fast", o_fast, rst_fast);
        adv_s = 0;
        adv_d = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0);
            if (adv_s == 0 && o_sml.x != 11'd0) adv_s = i;
            if (adv_d == 0 && o_def.x != 11'd0) adv_d = i;
        end
        check_int("first_adv_sml", adv_s, 3);
        check_int("first_adv_def", adv_d, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
